logic_op_arbiter: RTL and testbench

- Shares one registered bitwise logic unit (AND/OR/XOR/NAND over WIDTH bits) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on each request port and on the single response port.
- Sits between the gate-level logic primitives and the blocks that need occasional wide bitwise operations. This avoids replicating the unit per requester.

---
 rtl/logic_op_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/logic_op_arbiter.sv | 173 +++++++++++++++++
 tb/tb_logic_op_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// ----------------------------------------------------------------------------
// logic_op_pkg
// Shared types for the logic-op arbiter slice.
//   op_e    : 2-bit bitwise op code carried on each request port.
//   state_e : control FSM states of the shared logic unit.
// ----------------------------------------------------------------------------
package logic_op_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Scans i_ptr, i_ptr+1, ... modulo
// NUM_REQ and selects the first asserted request.
// Ports:
//   i_req      : request vector
//   i_ptr      : highest-priority index (must be < NUM_REQ)
//   o_grant    : one-hot grant, zero when no request
//   o_grant_id : index of the granted requester
//   o_any      : at least one request asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_any
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W-1:0]      w_offset;
    logic [ID_W:0]        w_sum;
    logic [ID_W:0]        w_wrap;
    logic                 w_unused;

    // Rotate so that bit j of w_rot is request (i_ptr + j) mod NUM_REQ.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Lowest set bit of the rotated vector is the nearest requester to i_ptr.
    always_comb begin
        w_offset = '0;
        o_any    = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_offset = ID_W'(j);
                o_any    = 1'b1;
            end
        end
    end

    // Undo the rotation: (i_ptr + offset) mod NUM_REQ without a divider.
    assign w_sum      = {1'b0, i_ptr} + {1'b0, w_offset};
    assign w_wrap     = (w_sum >= NUM_REQ_W) ? (w_sum - NUM_REQ_W) : w_sum;
    assign o_grant_id = w_wrap[ID_W-1:0];

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_any && (o_grant_id == ID_W'(i));
        end
    end

    assign w_unused = ^{w_dbl[2*NUM_REQ-1:NUM_REQ], w_wrap[ID_W]};

endmodule

// File: rtl/logic_op_arbiter.sv
// ----------------------------------------------------------------------------
// logic_op_arbiter
// One registered bitwise logic unit (AND/OR/XOR/NAND) shared by NUM_REQ
// requesters under round-robin arbitration. One transaction in flight at a
// time: IDLE (grant/capture) -> EXEC (compute) -> RESP (hold until accepted).
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req_valid      : per-requester valid
//   o_req_ready      : per-requester accept, one-hot or zero
//   i_req_a, i_req_b : packed operands, requester i at [i*WIDTH +: WIDTH]
//   i_req_op         : packed op codes, requester i at [i*2 +: 2]
//   o_rsp_valid      : result valid
//   i_rsp_ready      : downstream accepts result
//   o_rsp_id         : requester the result belongs to
//   o_rsp_y          : result
//   o_busy           : FSM not idle
//   o_txn_count      : completed responses, wraps
// ----------------------------------------------------------------------------
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ*2-1:0]   i_req_op,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [WIDTH-1:0]       o_rsp_y,
    output logic                   o_busy,
    output logic [CNT_W-1:0]       o_txn_count
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    op_e                r_op;
    logic [ID_W-1:0]    r_grant_id;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_y;
    logic [CNT_W-1:0]   r_txn_count;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_any;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [1:0]         w_sel_op;
    logic               w_handshake;
    logic               w_accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req      (i_req_valid),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a  = i_req_a[i*WIDTH +: WIDTH];
                w_sel_b  = i_req_b[i*WIDTH +: WIDTH];
                w_sel_op = i_req_op[i*2 +: 2];
            end
        end
    end

    // Next state and handshake decode. The grant only contains valid bits, so
    // presenting it as ready is itself the handshake.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        w_handshake = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by reset so no requester sees ready while held in reset.
                if (w_any && i_rst_n) begin
                    o_req_ready = w_grant;
                    w_handshake = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (r_rsp_valid && i_rsp_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_AND;
            r_grant_id  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
            r_txn_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_handshake) begin
                r_a        <= w_sel_a;
                r_b        <= w_sel_b;
                r_op       <= op_e'(w_sel_op);
                r_grant_id <= w_grant_id;
            end

            if (r_state == ST_EXEC) begin
                case (r_op)
                    OP_AND:  r_rsp_y <= r_a & r_b;
                    OP_OR:   r_rsp_y <= r_a | r_b;
                    OP_XOR:  r_rsp_y <= r_a ^ r_b;
                    OP_NAND: r_rsp_y <= ~(r_a & r_b);
                    default: r_rsp_y <= r_a & r_b;
                endcase
                r_rsp_id    <= r_grant_id;
                r_rsp_valid <= 1'b1;
            end

            if (w_accept) begin
                r_rsp_valid <= 1'b0;
                r_txn_count <= r_txn_count + 1'b1;
                // Pointer moves only on accept: the requester just served
                // becomes lowest priority.
                if (r_grant_id == ID_W'(NUM_REQ - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= r_grant_id + 1'b1;
                end
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_y     = r_rsp_y;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_txn_count = r_txn_count;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// ----------------------------------------------------------------------------
// tb_logic_op_arbiter
// Self-checking bench: directed ops, round-robin order, back-pressure, sparse
// fairness, reset mid-response, and randomized traffic checked against a
// behavioural model (last-served pointer, plain-operator results, counter).
// CNT_W is reduced to 4 so the counter wrap is reached quickly.
// ----------------------------------------------------------------------------
module tb_logic_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_y;
    logic                     busy;
    logic [CNT_W-1:0]         txn_count;

    // Per-requester stimulus, packed onto the DUT buses below.
    logic [NUM_REQ-1:0] tv;
    logic [WIDTH-1:0]   opa [NUM_REQ];
    logic [WIDTH-1:0]   opb [NUM_REQ];
    logic [1:0]         opc [NUM_REQ];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int last_served = NUM_REQ - 1;
    int exp_count   = 0;
    int accepts     = 0;
    logic [WIDTH-1:0] last_y;
    logic [ID_W-1:0]  last_id;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = tv;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = opa[i];
            req_b[i*WIDTH +: WIDTH] = opb[i];
            req_op[i*2 +: 2]        = opc[i];
        end
    end

    logic_op_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_op    (req_op),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_y     (rsp_y),
        .o_busy      (busy),
        .o_txn_count (txn_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Winner: first valid requester after the one served last.
    function automatic int ref_winner(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last_served + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One full transaction starting in an IDLE cycle with tv already driven.
    // keep=1: winner keeps requesting with the same operands afterwards.
    // keep=0: winner drops valid and scrambles its operands after the grant.
    task automatic run_txn(input int bp, input bit keep);
        int w;
        logic [WIDTH-1:0] ey;
        #1;
        w = ref_winner(tv);
        check_eq("grant_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w < 0) return;
        ey = ref_op(opc[w], opa[w], opb[w]);
        @(posedge clk); #1;
        if (!keep) begin
            tv[w]  = 1'b0;
            opa[w] = WIDTH'($urandom);
            opb[w] = WIDTH'($urandom);
            opc[w] = 2'($urandom);
        end
        rsp_ready = (bp == 0);
        #3;
        check_eq("exec_valid", 32'(rsp_valid), 32'd0);
        check_eq("exec_ready", 32'(req_ready), 32'd0);
        check_eq("exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_id", 32'(rsp_id), 32'(w));
        check_eq("rsp_y", 32'(rsp_y), 32'(ey));
        check_eq("resp_ready", 32'(req_ready), 32'd0);
        last_y  = rsp_y;
        last_id = rsp_id;
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            if (k == bp - 1) rsp_ready = 1'b1;
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_id", 32'(rsp_id), 32'(w));
            check_eq("bp_y", 32'(rsp_y), 32'(ey));
            check_eq("bp_ready", 32'(req_ready), 32'd0);
            check_eq("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        last_served = w;
        exp_count   = (exp_count + 1) % (1 << CNT_W);
        accepts++;
        check_eq("acc_valid", 32'(rsp_valid), 32'd0);
        check_eq("acc_busy", 32'(busy), 32'd0);
        check_eq("txn_count", 32'(txn_count), 32'(exp_count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] single_exp [4];
        single_exp[0] = 8'h30;
        single_exp[1] = 8'hFC;
        single_exp[2] = 8'hCC;
        single_exp[3] = 8'hCF;

        rsp_ready = 1'b1;
        tv        = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = WIDTH'(8'h11 * (i + 1));
            opb[i] = WIDTH'(8'h5A ^ (i * 8'h21));
            opc[i] = 2'(i);
        end

        // Reset state with every requester asserting valid.
        #12;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(txn_count), 32'd0);
        check_eq("rst_y", 32'(rsp_y), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin with all requesters continuously valid: 0,1,2,3,0,1.
        for (int t = 0; t < 6; t++) begin
            run_txn(0, 1'b1);
            check_eq("rr_order", 32'(last_id), 32'(t % NUM_REQ));
        end
        tv = '0;

        // Single ops on requester 2.
        for (int k = 0; k < 4; k++) begin
            opa[2] = 8'hF0;
            opb[2] = 8'h3C;
            opc[2] = 2'(k);
            tv     = 4'b0100;
            run_txn(0, 1'b0);
            check_eq("single_y", 32'(last_y), 32'(single_exp[k]));
        end

        // Back-pressure for 5 cycles while others keep requesting.
        tv = 4'b1011;
        run_txn(5, 1'b0);
        tv = '0;

        // Sparse fairness: serve 3, then 1 and 3 both valid -> 1 then 3.
        tv = 4'b1000;
        run_txn(0, 1'b0);
        tv = 4'b1010;
        run_txn(0, 1'b1);
        check_eq("sparse_first", 32'(last_id), 32'd1);
        run_txn(0, 1'b1);
        check_eq("sparse_second", 32'(last_id), 32'd3);
        tv = '0;

        // Reset while a response is being held.
        rsp_ready = 1'b0;
        tv        = 4'b0001;
        @(posedge clk); #1;
        tv = '0;
        @(posedge clk); #1;
        check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        tv    = '1;
        #1;
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_y", 32'(rsp_y), 32'd0);
        check_eq("mid_rst_count", 32'(txn_count), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        tv = '0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        rsp_ready   = 1'b1;
        last_served = NUM_REQ - 1;
        exp_count   = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
            check_eq("post_rst_count", 32'(txn_count), 32'd0);
        end

        // Randomized traffic; runs past 16 accepts so the counter wraps.
        accepts = 0;
        for (int it = 0; it < 300 && accepts < 24; it++) begin
            tv = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                opa[i] = WIDTH'($urandom);
                opb[i] = WIDTH'($urandom);
                opc[i] = 2'($urandom);
            end
            if (tv == '0) begin
                #1;
                check_eq("idle_ready", 32'(req_ready), 32'd0);
                check_eq("idle_busy", 32'(busy), 32'd0);
                @(posedge clk); #1;
                check_eq("idle_count", 32'(txn_count), 32'(exp_count));
            end else begin
                run_txn(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
        end
        tv = '0;
        check_eq("wrap_reached", 32'(accepts >= 24), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
